peripheral_rxfifo: RTL and testbench

PERIPHERAL_RXFIFO -- requirements
Module: peripheral_rxfifo

---
 rtl/peripheral_rxfifo.sv | 168 ++++++++++++++++
 tb/tb_peripheral_rxfifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_rxfifo.sv
// UART receiver (8N1) feeding a 16-entry byte FIFO, read and controlled through
// the J1 I/O bus: DATA at 0x0, STATUS at 0x2, CTRL (write-only) at 0x4.
module peripheral_rxfifo #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_led
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    rx_state_e   state_q, state_d;
    logic        rx_meta_q, rx_sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_push, ferr_set;

    logic [7:0]  mem [16];
    logic [3:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]  count_q, count_d;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic        pop_prev_q;
    logic        pop_term, pop, push_ok, full, empty;
    logic        ctrl_wr, flush, clr_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // Sample points are counted from the middle of the start bit onwards.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    rx_push  = rx_sync_q;
                    ferr_set = ~rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_led = (state_q != IDLE);
    end

    assign full     = (count_q == 5'd16);
    assign empty    = (count_q == 5'd0);
    assign pop_term = cs & rd & (addr == 4'h0);
    assign pop      = pop_term & ~pop_prev_q & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push_ok  = rx_push & (~full | pop);
    assign ctrl_wr  = cs & wr & (addr == 4'h4);
    assign flush    = ctrl_wr & d_in[0];
    assign clr_err  = ctrl_wr & d_in[1];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_d = count_q + 1'b1;
            else if (!push_ok && pop) count_d = count_q - 1'b1;
        end
        overrun_d   = (overrun_q & ~clr_err) | (rx_push & ~push_ok & ~flush);
        frame_err_d = (frame_err_q & ~clr_err) | ferr_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            pop_prev_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            pop_prev_q  <= pop_term;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        d_out = '0;
        if (cs && rd) begin
            case (addr)
                4'h0: if (!empty) d_out = {8'h00, mem[rd_ptr_q]};
                4'h2: d_out = {4'b0, frame_err_q, overrun_q, full, empty, 3'b0, count_q};
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_rxfifo.sv
// Directed and randomized bench for peripheral_rxfifo, checked against a
// queue-based model of the FIFO and its sticky error flags.
module tb_peripheral_rxfifo;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, uart_rx = 1'b1;
    logic [3:0]  addr = '0;
    logic [15:0] d_in = '0;
    logic [15:0] d_out;
    logic        rx_led;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ref_q[$];
    bit         ref_ovr = 1'b0;
    bit         ref_ferr = 1'b0;

    always #5 clk = ~clk;

    peripheral_rxfifo #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .uart_rx(uart_rx), .rx_led(rx_led)
    );

    function automatic logic [15:0] exp_status();
        int n = ref_q.size();
        return {4'b0, ref_ferr, ref_ovr, n == 16, n == 0, 3'b0, n[4:0]};
    endfunction

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)              ref_ferr = 1'b1;
        else if (ref_q.size() < 16) ref_q.push_back(b);
        else                       ref_ovr = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge once the line has idled 2 bit times.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        model_rx(b, stop_ok);
    endtask

    task automatic read_data(input string tag);
        logic [15:0] exp;
        exp = (ref_q.size() > 0) ? {8'h00, ref_q[0]} : 16'h0000;
        cs = 1'b1; rd = 1'b1; addr = 4'h0;
        #1 check16(tag, d_out, exp);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        if (ref_q.size() > 0) void'(ref_q.pop_front());
        @(negedge clk);
    endtask

    task automatic read_status(input string tag);
        cs = 1'b1; rd = 1'b1; addr = 4'h2;
        #1 check16(tag, d_out, exp_status());
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic ctrl_write(input logic chip, input logic [15:0] v);
        cs = chip; wr = 1'b1; addr = 4'h4; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = '0;
        if (chip) begin
            if (v[0]) ref_q.delete();
            if (v[1]) begin ref_ovr = 1'b0; ref_ferr = 1'b0; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] nb;
        bit seen;

        repeat (3) @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 4'h2;
        #1 check16("reset_status", d_out, 16'h0100);
        check16("reset_led", {15'b0, rx_led}, 16'h0000);
        cs = 1'b0;
        #1 check16("idle_dout_cs_low", d_out, 16'h0000);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // single frame 0xA5
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (40) @(negedge clk);
                #1 check16("led_mid_frame", {15'b0, rx_led}, 16'h0001);
            end
        join
        read_status("a5_status");
        read_data("a5_data");
        read_status("a5_status_after");

        // framing error, then clear; writes with cs low ignored
        send_frame(8'h3C, 1'b0);
        read_status("ferr_status");
        ctrl_write(1'b0, 16'h0003);
        read_status("ferr_cs_low_write");
        ctrl_write(1'b1, 16'h0002);
        read_status("ferr_cleared");

        // 4-cycle glitch
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rx_led) seen = 1'b1;
        end
        check16("glitch_led_pulse", {15'b0, seen}, 16'h0001);
        check16("glitch_led_idle", {15'b0, rx_led}, 16'h0000);
        read_status("glitch_status");

        // overrun
        for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
        read_status("overrun_status");
        for (int i = 0; i < 16; i++) read_data($sformatf("drain_%0d", i));
        read_data("drain_empty");
        read_status("drain_status");
        ctrl_write(1'b1, 16'h0002);

        // full FIFO, pop coincident with the stop-bit push
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1);
        nb = 8'($urandom);
        fork
            send_frame(nb, 1'b1);
            begin
                repeat (154) @(negedge clk);
                cs = 1'b1; rd = 1'b1; addr = 4'h0;
                #1 check16("coinc_head", d_out, {8'h00, ref_q[0]});
                @(negedge clk);
                cs = 1'b0; rd = 1'b0;
                void'(ref_q.pop_front());
            end
        join
        read_status("coinc_status");
        for (int i = 0; i < 16; i++) read_data($sformatf("coinc_drain_%0d", i));
        read_status("coinc_empty");

        // long strobe pops once, flush, reset mid-frame
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
        cs = 1'b1; rd = 1'b1; addr = 4'h0;
        repeat (5) @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        void'(ref_q.pop_front());
        @(negedge clk);
        read_status("long_strobe_status");
        ctrl_write(1'b1, 16'h0001);
        read_status("flush_status");

        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        #1 check16("rst_pre_led", {15'b0, rx_led}, 16'h0001);
        rst = 1'b0;
        #1 check16("rst_async_led", {15'b0, rx_led}, 16'h0000);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        read_status("rst_mid_frame_status");
        send_frame(8'($urandom), 1'b1);
        read_data("rst_resume_data");

        // randomized traffic
        ctrl_write(1'b1, 16'h0003);
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0, 1: send_frame(8'($urandom), $urandom_range(0, 7) != 0);
                2: read_data($sformatf("rand_data_%0d", it));
                3: read_status($sformatf("rand_status_%0d", it));
                default: ctrl_write(1'($urandom), {14'b0, 2'($urandom)});
            endcase
        end
        read_status("rand_final_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
